// File: rtl/counter_cycle_scheduler.sv
// counter_cycle_scheduler
//   Schedules involuntary counter cycles (PINC/MINC) against the memory-cycle
//   timepulse sequence. Up/down request edges are latched per counter and
//   opposing requests cancel. At each T12 rise the lowest-index pending
//   counter is granted the next memory cycle, limited to MAXBURST consecutive
//   counter cycles before an instruction cycle is forced. GOJAM flushes all
//   scheduling state.
//
// Ports
//   SIM_CLK   clock, all state on rising edge
//   SIM_RST   asynchronous reset, active-low
//   T12       timepulse 12 level
//   GOJAM     synchronous restart flush
//   CTINH     inhibit counter grants (sampled at T12 rise)
//   REQ_UP    per-counter increment request levels (rising edge = request)
//   REQ_DN    per-counter decrement request levels (rising edge = request)
//   CNTCYC    current memory cycle is a counter cycle
//   CNT_ADDR  ADDR_BASE + granted index, valid while CNTCYC
//   CNT_MINC  0 = PINC, 1 = MINC, valid while CNTCYC
//   PEND_ANY  any counter pending (registered)
//   OVRUN     one-cycle pulse: repeat edge on an already-pending direction
module counter_cycle_scheduler #(
  parameter int NCNT      = 20,
  parameter int ADDR_BASE = 20,
  parameter int AW        = 12,
  parameter int MAXBURST  = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            T12,
  input  logic            GOJAM,
  input  logic            CTINH,
  input  logic [NCNT-1:0] REQ_UP,
  input  logic [NCNT-1:0] REQ_DN,
  output logic            CNTCYC,
  output logic [AW-1:0]   CNT_ADDR,
  output logic            CNT_MINC,
  output logic            PEND_ANY,
  output logic            OVRUN
);

  localparam int            IW        = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam logic [AW-1:0] BASE      = AW'(ADDR_BASE);
  localparam logic [3:0]    BURST_MAX = 4'(MAXBURST);

  typedef enum logic {INSTR, COUNT} sched_t;

  sched_t          state, state_nxt;
  logic            t12_q;
  logic [NCNT-1:0] up_q, dn_q;
  logic [NCNT-1:0] pend_up, pend_dn, pend_up_nxt, pend_dn_nxt;
  logic [3:0]      burst, burst_nxt;
  logic [AW-1:0]   addr_nxt;
  logic            minc_nxt;
  logic            t12_rise;
  logic [NCNT-1:0] up_e, dn_e;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            grant;
  logic            ovr_nxt;

  assign t12_rise = T12 & ~t12_q;
  assign up_e     = REQ_UP & ~up_q;
  assign dn_e     = REQ_DN & ~dn_q;
  assign CNTCYC   = (state == COUNT);

  // Lowest-index pending counter wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (!win_found && (pend_up[i] || pend_dn[i])) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  // Scheduler next state and registered cycle outputs.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    addr_nxt  = CNT_ADDR;
    minc_nxt  = CNT_MINC;
    grant     = 1'b0;
    if (GOJAM) begin
      state_nxt = INSTR;
      burst_nxt = '0;
    end else if (t12_rise) begin
      if (win_found && !CTINH && (burst < BURST_MAX)) begin
        grant     = 1'b1;
        state_nxt = COUNT;
        burst_nxt = burst + 4'd1;
        addr_nxt  = BASE + AW'(win_idx);
        minc_nxt  = pend_dn[win_idx];
      end else begin
        state_nxt = INSTR;
        burst_nxt = '0;
      end
    end
  end

  // Pending update: the grant consumes the pre-edge state first, then this
  // cycle's edges are applied to the result, so a grant coinciding with a
  // same-direction edge re-pends the counter instead of reporting overrun.
  // Simultaneous up and down edges net to zero.
  always_comb begin
    pend_up_nxt = pend_up;
    pend_dn_nxt = pend_dn;
    ovr_nxt     = 1'b0;
    if (grant) begin
      pend_up_nxt[win_idx] = 1'b0;
      pend_dn_nxt[win_idx] = 1'b0;
    end
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (up_e[i] && !dn_e[i]) begin
        if (pend_dn_nxt[i])      pend_dn_nxt[i] = 1'b0;
        else if (pend_up_nxt[i]) ovr_nxt        = 1'b1;
        else                     pend_up_nxt[i] = 1'b1;
      end else if (dn_e[i] && !up_e[i]) begin
        if (pend_up_nxt[i])      pend_up_nxt[i] = 1'b0;
        else if (pend_dn_nxt[i]) ovr_nxt        = 1'b1;
        else                     pend_dn_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state    <= INSTR;
      burst    <= '0;
      CNT_ADDR <= '0;
      CNT_MINC <= 1'b0;
    end else begin
      state    <= state_nxt;
      burst    <= burst_nxt;
      CNT_ADDR <= addr_nxt;
      CNT_MINC <= minc_nxt;
    end
  end

  // Edge history keeps tracking during GOJAM so held levels do not re-trigger.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      t12_q    <= 1'b0;
      up_q     <= '0;
      dn_q     <= '0;
      pend_up  <= '0;
      pend_dn  <= '0;
      PEND_ANY <= 1'b0;
      OVRUN    <= 1'b0;
    end else begin
      t12_q <= T12;
      up_q  <= REQ_UP;
      dn_q  <= REQ_DN;
      if (GOJAM) begin
        pend_up  <= '0;
        pend_dn  <= '0;
        PEND_ANY <= 1'b0;
        OVRUN    <= 1'b0;
      end else begin
        pend_up  <= pend_up_nxt;
        pend_dn  <= pend_dn_nxt;
        PEND_ANY <= |(pend_up | pend_dn);
        OVRUN    <= ovr_nxt;
      end
    end
  end

endmodule
